// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared fetch/decode bus widths, reset PC and redirect-target priority
package ifetch_queue_pkg;
  localparam int D2F_BRC_WID = 34;
  localparam int F2D_WID = 65;
  localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;
  typedef struct packed {
    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
  } d2f_brc_t;
  typedef struct packed {
    logic        adef;
    logic [31:0] inst;
    logic [31:0] pc;
  } f2d_t;
  function automatic logic [31:0] redirect_target(input logic wb_ex, input logic ertn_flush,
                                                  input logic [31:0] ex_entry, input logic [31:0] ertn_entry,
                                                  input logic [31:0] br_target);
    return wb_ex ? ex_entry : ertn_flush ? ertn_entry : br_target;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: flushable circular FIFO with occupancy count; callers guarantee no overflow or underflow
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    wr_d  = flush_i ? '0 : push_i ? inc(wr_q) : wr_q;
    rd_d  = flush_i ? '0 : pop_i ? inc(rd_q) : rd_q;
    cnt_d = flush_i ? '0 : cnt_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= din_i;
  end
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: credit-based instruction fetch with in-order pc queue, cancel counter and instruction buffer
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          OUTSTANDING = 2,
  parameter int          IBUF_DEPTH  = 4,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   inst_sram_req,
  output logic                   inst_sram_wr,
  output logic [1:0]             inst_sram_size,
  output logic [3:0]             inst_sram_wstrb,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic                   inst_sram_addr_ok,
  input  logic                   inst_sram_data_ok,
  input  logic [31:0]            inst_sram_rdata,
  input  logic [D2F_BRC_WID-1:0] br_collect,
  input  logic                   wb_ex,
  input  logic                   ertn_flush,
  input  logic [31:0]            ex_entry,
  input  logic [31:0]            ertn_entry,
  input  logic                   ds_allowin,
  output logic                   fs_to_ds_valid,
  output logic [F2D_WID-1:0]     fs_to_ds_bus
);
  localparam int IW = $clog2(OUTSTANDING + 1);
  localparam int BW = $clog2(IBUF_DEPTH + 1);
  d2f_brc_t brc;
  f2d_t ibuf_din;
  logic redirect, misaligned, accept, ret, drop, adef_push, ibuf_push, ibuf_pop;
  logic halted_q, halted_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, pcq_head;
  logic [IW-1:0] inflight, cancel_q, cancel_d;
  logic [BW-1:0] ibuf_count;
  assign brc        = br_collect;
  assign redirect   = wb_ex | ertn_flush | brc.br_taken;
  assign misaligned = |fetch_pc_q[1:0];
  // every issued request already owns a buffer slot, so the ibuf can never overflow
  assign inst_sram_req = ~reset & ~redirect & ~brc.br_stall & ~halted_q & ~misaligned
                       & (32'(inflight) < OUTSTANDING)
                       & (32'(inflight) + 32'(ibuf_count) < IBUF_DEPTH);
  assign accept    = inst_sram_req & inst_sram_addr_ok;
  assign ret       = inst_sram_data_ok & (inflight != '0);
  assign drop      = ret & ((cancel_q != '0) | redirect);
  assign adef_push = misaligned & ~halted_q & ~redirect & (inflight == '0) & (cancel_q == '0)
                   & (32'(ibuf_count) < IBUF_DEPTH);
  assign ibuf_push = (ret & ~drop) | adef_push;
  assign ibuf_pop  = fs_to_ds_valid & ds_allowin & ~redirect;
  assign ibuf_din  = adef_push ? {1'b1, 32'h0, fetch_pc_q} : {1'b0, inst_sram_rdata, pcq_head};
  always_comb begin
    fetch_pc_d = redirect ? redirect_target(wb_ex, ertn_flush, ex_entry, ertn_entry, brc.br_target)
               : accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    cancel_d   = redirect ? inflight - IW'(ret) : cancel_q - IW'(ret & (cancel_q != '0));
    halted_d   = ~redirect & (halted_q | adef_push);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      cancel_q   <= '0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      cancel_q   <= cancel_d;
      halted_q   <= halted_d;
    end
  end
  sync_fifo #(.WIDTH(32), .DEPTH(OUTSTANDING)) u_pcq (
    .clk(clk), .reset(reset), .push_i(accept), .pop_i(ret), .flush_i(1'b0),
    .din_i(fetch_pc_q), .dout_o(pcq_head), .count_o(inflight)
  );
  sync_fifo #(.WIDTH(F2D_WID), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk(clk), .reset(reset), .push_i(ibuf_push), .pop_i(ibuf_pop), .flush_i(redirect),
    .din_i(ibuf_din), .dout_o(fs_to_ds_bus), .count_o(ibuf_count)
  );
  assign fs_to_ds_valid  = ibuf_count != '0;
  assign inst_sram_addr  = fetch_pc_q;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: constant-vector table plus scoreboard of delivered fetch packets against a bus model
module tb_ifetch_queue;
  localparam logic [31:0] RPC = 32'h1c000000;
  typedef struct packed { logic [31:0] a; logic st; } pend_t;
  typedef struct packed {
    logic aok, dok, ds, req;
    logic [31:0] addr;
    logic valid;
    logic [31:0] pc;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1;
  logic req, wr, aok, dok, ds, valid, dok_en;
  logic [1:0] size;
  logic [3:0] wstrb;
  logic [31:0] addr, wdata, rdata;
  logic br_stall, br_taken, wb_ex, ertn;
  logic [31:0] br_tgt, ex_entry, ertn_entry;
  logic [64:0] bus;
  int errs = 0, checks = 0;
  pend_t slv_q[$];
  logic [64:0] exp_q[$], deliv_q[$];
  logic [31:0] m_pc, s_tgt;
  logic m_halt, s_redir, s_adef, s_req, e_req;
  vec_t tbl[18];

  always #5 clk = ~clk;

  ifetch_queue dut (
    .clk(clk), .reset(reset), .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
    .inst_sram_wstrb(wstrb), .inst_sram_addr(addr), .inst_sram_wdata(wdata),
    .inst_sram_addr_ok(aok), .inst_sram_data_ok(dok), .inst_sram_rdata(rdata),
    .br_collect({br_stall, br_taken, br_tgt}), .wb_ex(wb_ex), .ertn_flush(ertn),
    .ex_entry(ex_entry), .ertn_entry(ertn_entry), .ds_allowin(ds),
    .fs_to_ds_valid(valid), .fs_to_ds_bus(bus)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h13572468;
  endfunction

  function automatic logic [64:0] ent(input logic [31:0] pc);
    return {1'b0, memf(pc), pc};
  endfunction

  function automatic vec_t mk(input logic a, input logic d, input logic s, input logic r,
                              input logic [31:0] ad, input logic v, input logic [31:0] p);
    return '{aok: a, dok: d, ds: s, req: r, addr: ad, valid: v, pc: p};
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mreset();
    reset = 1'b1;
    {aok, dok, dok_en, ds, br_stall, br_taken, wb_ex, ertn} = '0;
    {br_tgt, ex_entry, ertn_entry, rdata} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", 65'(req), 65'(0));
    chk("rst_valid", 65'(valid), 65'(0));
    slv_q.delete();
    exp_q.delete();
    deliv_q.delete();
    m_pc = RPC;
    m_halt = 1'b0;
    reset = 1'b0;
  endtask

  task automatic drive();
    dok = dok_en && slv_q.size() > 0;
    rdata = dok ? memf(slv_q[0].a) : 32'hdeadbeef;
    #1;
    s_redir = wb_ex | ertn | br_taken;
    s_tgt = wb_ex ? ex_entry : ertn ? ertn_entry : br_tgt;
    s_req = req;
    e_req = !s_redir && !br_stall && !m_halt && m_pc[1:0] == 2'b00 && slv_q.size() < 2
            && slv_q.size() + exp_q.size() < 4;
    s_adef = !s_redir && m_pc[1:0] != 2'b00 && !m_halt && slv_q.size() == 0 && exp_q.size() < 4;
    chk("req", 65'(req), 65'(e_req));
    if (req) chk("addr", 65'(addr), 65'(m_pc));
    chk("valid", 65'(valid), 65'(exp_q.size() != 0));
  endtask

  task automatic advance();
    pend_t e;
    logic [64:0] x;
    if (valid && ds && !s_redir) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL deliver: got %h expected no delivery", bus);
      end else begin
        x = exp_q.pop_front();
        chk("deliver", bus, x);
      end
      deliv_q.push_back(bus);
    end
    if (dok) begin
      e = slv_q.pop_front();
      if (!e.st && !s_redir) exp_q.push_back(ent(e.a));
    end
    if (s_req && aok) begin
      slv_q.push_back('{a: m_pc, st: 1'b0});
      m_pc += 32'd4;
    end
    if (s_adef) begin
      exp_q.push_back({1'b1, 32'h0, m_pc});
      m_halt = 1'b1;
    end
    if (s_redir) begin
      exp_q.delete();
      foreach (slv_q[i]) slv_q[i].st = 1'b1;
      m_pc = s_tgt;
      m_halt = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive();
      advance();
    end
  endtask

  task automatic chk_deliv(input string name, input int i, input logic [64:0] exp);
    chk(name, i < deliv_q.size() ? deliv_q[i] : 65'h0, exp);
  endtask

  initial begin
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b1, RPC,         1'b0, 32'h0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b1, RPC + 32'h4, 1'b0, 32'h0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b1, RPC + 32'h8, 1'b1, RPC);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,       1'b1, RPC);
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, 1'b1, RPC + 32'hc, 1'b1, RPC);
    tbl[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, RPC);
    tbl[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,       1'b1, RPC);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, RPC);
    tbl[11] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,       1'b1, RPC);
    tbl[12] = mk(1'b1, 1'b0, 1'b1, 1'b1, RPC + 32'h10, 1'b1, RPC + 32'h4);
    tbl[13] = mk(1'b0, 1'b0, 1'b1, 1'b1, RPC + 32'h14, 1'b1, RPC + 32'h8);
    tbl[14] = mk(1'b0, 1'b0, 1'b1, 1'b1, RPC + 32'h14, 1'b1, RPC + 32'hc);
    tbl[15] = mk(1'b0, 1'b1, 1'b1, 1'b1, RPC + 32'h14, 1'b0, 32'h0);
    tbl[16] = mk(1'b0, 1'b0, 1'b1, 1'b1, RPC + 32'h14, 1'b1, RPC + 32'h10);
    tbl[17] = mk(1'b0, 1'b0, 1'b1, 1'b1, RPC + 32'h14, 1'b0, 32'h0);

    mreset();
    chk("ties", 65'({wr, size, wstrb, wdata}), 65'({1'b0, 2'b10, 4'h0, 32'h0}));
    for (int i = 0; i < 18; i++) begin
      aok = tbl[i].aok;
      dok_en = tbl[i].dok;
      ds = tbl[i].ds;
      drive();
      chk("t_req", 65'(req), 65'(tbl[i].req));
      if (tbl[i].req) chk("t_addr", 65'(addr), 65'(tbl[i].addr));
      chk("t_valid", 65'(valid), 65'(tbl[i].valid));
      if (tbl[i].valid) chk("t_bus", bus, ent(tbl[i].pc));
      advance();
    end

    // straight-line fetch with 1-cycle responses
    mreset();
    aok = 1'b1; dok_en = 1'b1; ds = 1'b1;
    run(10);
    chk("a_cnt", 65'(deliv_q.size() >= 3), 65'(1));
    for (int i = 0; i < 3; i++) chk_deliv("a_pc", i, ent(RPC + 32'(4 * i)));

    // two in flight, then a taken branch cancels both
    mreset();
    aok = 1'b1; dok_en = 1'b0; ds = 1'b1;
    run(5);
    chk("b_accepts", 65'(slv_q.size()), 65'(2));
    br_taken = 1'b1; br_tgt = RPC + 32'h100;
    run(1);
    br_taken = 1'b0; dok_en = 1'b1;
    deliv_q.delete();
    run(10);
    chk_deliv("b_first", 0, ent(RPC + 32'h100));

    // decode stalls long enough to fill the buffer, then drains in order
    mreset();
    aok = 1'b1; dok_en = 1'b1; ds = 1'b0;
    run(10);
    chk("c_valid", 65'(valid), 65'(1));
    chk("c_req", 65'(req), 65'(0));
    ds = 1'b1;
    run(8);
    for (int i = 0; i < 4; i++) chk_deliv("c_pc", i, ent(RPC + 32'(4 * i)));

    // exception beats branch, misaligned ertn target halts, branch resumes under br_stall
    mreset();
    aok = 1'b1; dok_en = 1'b1; ds = 1'b1;
    run(4);
    wb_ex = 1'b1; br_taken = 1'b1; ex_entry = RPC + 32'h1000; br_tgt = RPC + 32'h200;
    run(1);
    wb_ex = 1'b0; br_taken = 1'b0;
    deliv_q.delete();
    run(6);
    chk_deliv("d_ex", 0, ent(RPC + 32'h1000));
    ertn = 1'b1; ertn_entry = RPC + 32'h2;
    run(1);
    ertn = 1'b0;
    deliv_q.delete();
    run(10);
    chk("d_adef_cnt", 65'(deliv_q.size()), 65'(1));
    chk_deliv("d_adef", 0, {1'b1, 32'h0, RPC + 32'h2});
    chk("d_halt_req", 65'(req), 65'(0));
    br_taken = 1'b1; br_tgt = RPC + 32'h300;
    run(1);
    br_taken = 1'b0;
    deliv_q.delete();
    run(2);
    br_stall = 1'b1;
    run(4);
    br_stall = 1'b0;
    run(6);
    chk_deliv("d_resume", 0, ent(RPC + 32'h300));
    chk("d_resume_cnt", 65'(deliv_q.size() >= 4), 65'(1));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
